// File: rtl/axis_pkt_merge.sv
// AXI-Stream packet merger: concatenates num_pkts input packets into one output
// frame by rewriting TLAST at acceptance, through a registered 2-entry skid buffer.
module axis_pkt_merge #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 32,
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESET,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [KEEP_WIDTH-1:0] S_AXIS_TKEEP,
  input  logic                  S_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [KEEP_WIDTH-1:0] M_AXIS_TKEEP,
  output logic                  M_AXIS_TLAST,
  input  logic [31:0]           cmd,
  input  logic [CNT_WIDTH-1:0]  num_pkts,
  output logic [31:0]           status,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_PASS} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic                  mid_pkt_q, mid_pkt_d;
  logic                  s_ready_q, s_ready_d;
  logic [31:0]           status_q, status_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;
  logic                  sk_valid_q, sk_valid_d;
  logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
  logic [KEEP_WIDTH-1:0] sk_keep_q, sk_keep_d;
  logic                  sk_last_q, sk_last_d;
  logic [1:0]            occ_q, occ_d;
  logic                  soft_rst, en, pass_req, cont;
  logic                  accept, xfer, frame_final, in_last;
  logic [CNT_WIDTH-1:0]  new_last_idx;
  logic                  unused_cmd_bits;

  assign soft_rst        = cmd[1];
  assign en              = cmd[0];
  assign pass_req        = cmd[2];
  assign cont            = cmd[3];
  assign unused_cmd_bits = ^cmd[31:4];

  assign accept       = s_ready_q & S_AXIS_TVALID;
  assign xfer         = m_valid_q & M_AXIS_TREADY;
  assign occ_q        = 2'(m_valid_q) + 2'(sk_valid_q);
  assign new_last_idx = (num_pkts == '0) ? '0 : num_pkts - CNT_WIDTH'(1);
  assign frame_final  = S_AXIS_TLAST && (pkt_cnt_q == last_idx_q);
  // Rewritten TLAST travels with the beat; passthrough keeps the original.
  assign in_last      = (state_q == S_PASS) ? S_AXIS_TLAST : frame_final;

  always_comb begin
    state_d     = state_q;
    pkt_cnt_d   = pkt_cnt_q;
    last_idx_d  = last_idx_q;
    mid_pkt_d   = mid_pkt_q;
    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(xfer && m_last_q);
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    sk_valid_d  = sk_valid_q;
    sk_data_d   = sk_data_q;
    sk_keep_d   = sk_keep_q;
    sk_last_d   = sk_last_q;

    // Skid buffer: output register refills from skid first, then from input.
    if (xfer || !m_valid_q) begin
      if (sk_valid_q) begin
        m_valid_d  = 1'b1;
        m_data_d   = sk_data_q;
        m_keep_d   = sk_keep_q;
        m_last_d   = sk_last_q;
        sk_valid_d = accept;
        if (accept) begin
          sk_data_d = S_AXIS_TDATA;
          sk_keep_d = S_AXIS_TKEEP;
          sk_last_d = in_last;
        end
      end else begin
        m_valid_d = accept;
        if (accept) begin
          m_data_d = S_AXIS_TDATA;
          m_keep_d = S_AXIS_TKEEP;
          m_last_d = in_last;
        end
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_data_d  = S_AXIS_TDATA;
      sk_keep_d  = S_AXIS_TKEEP;
      sk_last_d  = in_last;
    end

    if (accept) mid_pkt_d = !S_AXIS_TLAST;

    case (state_q)
      S_IDLE: begin
        if (pass_req) begin
          state_d = S_PASS;
        end else if (en) begin
          state_d    = S_RUN;
          pkt_cnt_d  = '0;
          last_idx_d = new_last_idx;
        end
      end
      S_RUN: begin
        if (accept && S_AXIS_TLAST) begin
          if (frame_final && cont && en && !pass_req) begin
            pkt_cnt_d  = '0;
            last_idx_d = new_last_idx;
          end else begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            if (frame_final) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: if (occ_q == 2'd0) state_d = S_DONE;
      S_DONE:  if (!en) state_d = S_IDLE;
      S_PASS: begin
        if (!pass_req && (accept ? S_AXIS_TLAST : !mid_pkt_q)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (soft_rst) begin
      state_d     = S_IDLE;
      pkt_cnt_d   = '0;
      last_idx_d  = '0;
      frame_cnt_d = '0;
      mid_pkt_d   = 1'b0;
      m_valid_d   = 1'b0;
      m_data_d    = '0;
      m_keep_d    = '0;
      m_last_d    = 1'b0;
      sk_valid_d  = 1'b0;
      sk_data_d   = '0;
      sk_keep_d   = '0;
      sk_last_d   = 1'b0;
    end

    occ_d     = 2'(m_valid_d) + 2'(sk_valid_d);
    s_ready_d = ((state_d == S_RUN) || (state_d == S_PASS)) && (occ_d != 2'd2);
    status_d  = {28'd0, occ_d != 2'd0, state_d == S_PASS, state_d == S_RUN, state_d == S_DONE};
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q     <= S_IDLE;
      pkt_cnt_q   <= '0;
      last_idx_q  <= '0;
      frame_cnt_q <= '0;
      mid_pkt_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      status_q    <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_keep_q   <= '0;
      sk_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_cnt_q   <= pkt_cnt_d;
      last_idx_q  <= last_idx_d;
      frame_cnt_q <= frame_cnt_d;
      mid_pkt_q   <= mid_pkt_d;
      s_ready_q   <= s_ready_d;
      status_q    <= status_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      sk_valid_q  <= sk_valid_d;
      sk_data_q   <= sk_data_d;
      sk_keep_q   <= sk_keep_d;
      sk_last_q   <= sk_last_d;
    end
  end

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TKEEP  = m_keep_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign status        = status_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_pkt_merge.sv
// Scoreboard bench for axis_pkt_merge: a packet-level model predicts the merged
// output stream; a negedge monitor checks every output transfer and stall.
module tb_axis_pkt_merge;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        m_valid, m_ready, m_last;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic [31:0] cmd, num_pkts, status, pkt_cnt, frame_cnt;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    rmode = 0;
  int    out_n = 0;
  int    first_cyc = 0;
  int    last_cyc = 0;
  bit    chk_stall = 1'b1;
  bit    done_seen = 1'b0;
  bit    held_v = 1'b0;
  beat_t held;
  beat_t exp_q[$];
  int    mdl_idx = 0;
  int    mdl_eff = 1;
  bit    mdl_pass = 1'b0;

  axis_pkt_merge #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TDATA(s_data),
    .S_AXIS_TKEEP(s_keep), .S_AXIS_TLAST(s_last),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data),
    .M_AXIS_TKEEP(m_keep), .M_AXIS_TLAST(m_last),
    .cmd(cmd), .num_pkts(num_pkts), .status(status),
    .pkt_cnt(pkt_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output ready pattern: 0 = always ready, 1 = random 50%, else held low.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) m_ready = 1'b1;
      else if (rmode == 1) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b0;
    end
  end

  // Monitor: a beat with valid&ready at negedge transfers at the next posedge.
  always @(negedge clk) begin
    if (status[0]) done_seen = 1'b1;
    if (chk_stall && held_v)
      chk("stall_hold", {m_valid, m_data, m_keep, m_last}, {1'b1, held});
    held_v = chk_stall && m_valid && !m_ready;
    held   = '{d: m_data, k: m_keep, l: m_last};
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {m_data, m_keep, m_last}, '0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_beat", {m_data, m_keep, m_last}, {e.d, e.k, e.l});
      end
      if (out_n == 0) first_cyc = cyc;
      last_cyc = cyc;
      out_n++;
    end
  end

  task automatic start(input logic [31:0] c, input logic [31:0] n);
    mdl_eff  = (n == 0) ? 1 : int'(n);
    mdl_pass = c[2];
    mdl_idx  = 0;
    out_n    = 0;
    num_pkts = n;
    cmd      = c;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (!ok) chk("input_accept_timeout", 80'(0), 80'(1));
  endtask

  // Model: a packet's last beat closes a frame when its index within the frame is eff-1.
  task automatic send_pkt(input int n, input int nsend, input bit gaps);
    for (int i = 0; i < nsend; i++) begin
      beat_t b;
      b.d = {$urandom, $urandom};
      b.k = 8'($urandom);
      b.l = (i == n - 1) && (mdl_pass || (mdl_idx % mdl_eff) == mdl_eff - 1);
      exp_q.push_back(b);
      drive_beat(b.d, b.k, i == n - 1);
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      if (gaps) #1;
    end
    if (nsend == n) mdl_idx++;
  endtask

  task automatic wait_drained(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 80'(exp_q.size()), 80'(0));
  endtask

  task automatic wait_status(input string name, input logic [31:0] exp);
    for (int t = 0; t < 200 && status !== exp; t++) @(negedge clk);
    chk(name, 80'(status), 80'(exp));
  endtask

  task automatic soft_flush();
    @(posedge clk);
    #1 cmd = 32'h2;
    @(posedge clk);
    #1 cmd = 32'h0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cmd = '0; num_pkts = '0;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {m_valid, s_ready, status, frame_cnt[15:0]}, '0);
    chk("reset_pkt_cnt", 80'(pkt_cnt), 80'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 80'(s_ready), 80'(0));
    @(posedge clk);
    #1;

    // Three 4-beat packets merged, full throughput.
    start(32'h1, 32'd3);
    for (int p = 0; p < 3; p++) send_pkt(4, 4, 1'b0);
    wait_drained("t1_drain");
    wait_status("t1_status", 32'h1);
    chk("t1_contiguous", 80'(last_cyc - first_cyc), 80'(11));
    chk("t1_frame_cnt", 80'(frame_cnt), 80'(1));
    chk("t1_pkt_cnt", 80'(pkt_cnt), 80'(3));
    soft_flush();

    // Same with random backpressure and input gaps.
    rmode = 1;
    start(32'h1, 32'd3);
    for (int p = 0; p < 3; p++) send_pkt(4, 4, 1'b1);
    wait_drained("t2_drain");
    wait_status("t2_status", 32'h1);
    chk("t2_beats", 80'(out_n), 80'(12));
    chk("t2_frame_cnt", 80'(frame_cnt), 80'(1));
    chk("t2_pkt_cnt", 80'(pkt_cnt), 80'(3));
    rmode = 0;
    soft_flush();

    // Continuous mode: six 1-beat packets -> three 2-beat frames.
    start(32'h9, 32'd2);
    done_seen = 1'b0;
    for (int p = 0; p < 6; p++) send_pkt(1, 1, 1'b0);
    wait_drained("t3_drain");
    wait_status("t3_status", 32'h2);
    chk("t3_frame_cnt", 80'(frame_cnt), 80'(3));
    chk("t3_pkt_cnt", 80'(pkt_cnt), 80'(0));
    chk("t3_done_never", 80'(done_seen), 80'(0));
    soft_flush();

    // num_pkts=0 behaves as 1.
    start(32'h1, 32'd0);
    send_pkt(5, 5, 1'b0);
    wait_drained("t4_drain");
    wait_status("t4_status", 32'h1);
    chk("t4_frame_cnt", 80'(frame_cnt), 80'(1));
    chk("t4_pkt_cnt", 80'(pkt_cnt), 80'(1));
    soft_flush();

    // Passthrough keeps every TLAST.
    rmode = 1;
    start(32'h4, 32'd3);
    for (int p = 0; p < 4; p++) send_pkt(2, 2, 1'b1);
    wait_drained("t5_drain");
    wait_status("t5_status", 32'h4);
    chk("t5_frame_cnt", 80'(frame_cnt), 80'(4));
    chk("t5_pkt_cnt", 80'(pkt_cnt), 80'(0));
    rmode = 0;
    soft_flush();

    // Mid-frame flush, first by soft reset then by AXIS_ARESET.
    chk_stall = 1'b0;
    for (int m = 0; m < 2; m++) begin
      rmode = 2;
      start(32'h1, 32'd1);
      @(posedge clk);
      #1;
      send_pkt(8, 2, 1'b0);
      exp_q.delete();
      if (m == 0) begin
        #1 cmd = 32'h2;
        @(posedge clk);
        #1 cmd = 32'h1;
        @(negedge clk);
      end else begin
        #1 rst = 1'b1;
        @(negedge clk);
      end
      chk("flush_outputs", {m_valid, s_ready, status[15:0], frame_cnt, pkt_cnt[14:0]}, '0);
      if (m == 1) begin
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("flush_ready_after_reset", 80'(s_ready), 80'(0));
      end
      @(posedge clk);
      #1 rmode = 0;
      start(32'h1, 32'd1);
      send_pkt(8, 8, 1'b0);
      wait_drained("flush_drain");
      wait_status("flush_status", 32'h1);
      chk("flush_frame_cnt", 80'(frame_cnt), 80'(1));
      chk("flush_beats", 80'(out_n), 80'(8));
      soft_flush();
    end

    chk("final_queue_empty", 80'(exp_q.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_pkt_merge.md
Name: axis_pkt_merge

Overview:
- Parametrised AXI-Stream packet merger for DMA paths: concatenates num_pkts consecutive input packets into one output packet.
- TLAST is suppressed on every packet except the last one of each merged frame.
- Adds a full-throughput skid buffer, TKEEP forwarding, a continuous (auto-rearm) mode, a passthrough mode, and frame/packet counters for software.
- Sits between a DMA MM2S/S2MM stream and downstream processing, controlled by a cmd/status register pair.

Parameters:
- DATA_WIDTH, 64, TDATA width in bits; multiple of 8.
- CNT_WIDTH, 32, width of num_pkts and of all counters.
- KEEP_WIDTH, DATA_WIDTH/8, TKEEP width; derived, not overridden.

Ports:
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESET  in  1  reset; asynchronous, active-high.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TREADY  out  1  input ready.
- S_AXIS_TDATA  in  DATA_WIDTH  input data.
- S_AXIS_TKEEP  in  KEEP_WIDTH  input byte enables.
- S_AXIS_TLAST  in  1  input packet end.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  output ready.
- M_AXIS_TDATA  out  DATA_WIDTH  output data.
- M_AXIS_TKEEP  out  KEEP_WIDTH  output byte enables.
- M_AXIS_TLAST  out  1  merged-frame end.
- cmd  in  32  [0] en, [1] soft reset, [2] passthrough, [3] continuous; other bits ignored.
- num_pkts  in  CNT_WIDTH  packets per merged frame; 0 is treated as 1.
- status  out  32  [0] done, [1] busy (RUN), [2] passthrough active, [3] buffer non-empty; other bits 0.
- pkt_cnt  out  CNT_WIDTH  input packets accepted in the current frame.
- frame_cnt  out  CNT_WIDTH  merged frames completed at the output since reset; wraps.

Behaviour:
- Reset (AXIS_ARESET high, async assert): all outputs and counters are 0, state IDLE, buffer empty.
  - S_AXIS_TREADY is 0 during reset and for the first cycle after deassertion.
- Soft reset (cmd[1]=1, sampled synchronously): same effect as reset.
  - Buffered beats are discarded.
  - Holds while asserted.
  - Overrides every other cmd bit.
- Datapath: 2-entry skid buffer (output register plus skid register).
  - S_AXIS_TREADY and all M_AXIS_* outputs are registered.
  - Input-to-output latency is 1 cycle.
  - Sustains 1 beat/cycle while M_AXIS_TREADY=1.
  - No beat is dropped or duplicated under any TREADY pattern.
  - M_AXIS_TVALID, once high, stays high with TDATA/TKEEP/TLAST stable until the beat transfers.
- The TLAST rewrite is applied at input acceptance and stored with the beat.
  - Stored TLAST = S_AXIS_TLAST & (pkt_cnt == eff_num-1), where eff_num = max(num_pkts,1).
  - num_pkts is sampled at IDLE->RUN and at each rearm; mid-frame changes are ignored.
- Input-side FSM, state IDLE:
  - S_AXIS_TREADY=0.
  - If cmd[2]=1, go to PASS.
  - Else if cmd[0]=1, go to RUN with pkt_cnt=0.
- State RUN:
  - S_AXIS_TREADY = buffer not full.
  - Each accepted beat with S_AXIS_TLAST=1 increments pkt_cnt.
  - When the frame-final beat is accepted:
    - If cmd[3]=1 and cmd[0]=1: stay in RUN, pkt_cnt=0.
    - Else: go to DRAIN.
  - cmd[0] or cmd[2] changes take effect only at a frame boundary; the current frame always completes.
- State DRAIN:
  - S_AXIS_TREADY=0.
  - Go to DONE when the buffer is empty and the final beat has transferred.
- State DONE:
  - status[0]=1, S_AXIS_TREADY=0, M_AXIS_TVALID=0.
  - Stays until soft reset or cmd[0]=0; then go to IDLE with status[0] cleared.
- State PASS:
  - Beats are forwarded through the skid buffer with TLAST unchanged; pkt_cnt is held.
  - frame_cnt increments per output TLAST.
  - When cmd[2]=0, return to IDLE at a packet boundary; the current packet completes.
- frame_cnt increments when an output beat with M_AXIS_TLAST=1 transfers, in RUN/DRAIN/PASS.
- Simultaneous input accept and output transfer in one cycle: both take effect and buffer occupancy is unchanged.
- status[1]=1 only in RUN. status[2]=1 only in PASS. status[3] = buffer occupancy != 0.

Test Plan:
- num_pkts=3, cmd=0x1, three 4-beat packets, M_AXIS_TREADY=1 -> 12 contiguous output beats, TLAST only on beat 12, status=0x1 after drain, frame_cnt=1, pkt_cnt=3.
- Same stimulus with random 50% M_AXIS_TREADY and random S_AXIS_TVALID gaps -> identical 12-beat data/TKEEP sequence, no output bubble while TVALID held, TDATA stable while stalled.
- cmd=0x9 (continuous), num_pkts=2, six 1-beat packets -> three 2-beat frames with TLAST on beats 2, 4, 6, frame_cnt=3, status[0] never set.
- num_pkts=0, cmd=0x1, one 5-beat packet -> 5 output beats with TLAST on beat 5, then DONE.
- cmd=0x4 (passthrough), four 2-beat packets -> each input TLAST reproduced on output, frame_cnt=4, pkt_cnt=0.
- Mid-frame (after 2 of 8 beats), pulse cmd[1] for one cycle, then cmd=0x1 with num_pkts=1 -> buffer flushed, counters 0, the next packet is output intact with correct TLAST; repeat the same flush using AXIS_ARESET with identical result.
